// File: rtl/mem_axi_traffic_gen.sv
// mem_axi_traffic_gen: AXI-MM write-then-readback traffic generator.
// Writes num_bursts INCR bursts of a seed-derived pattern, reads them back
// and counts mismatching beats. Only one transaction is outstanding.
//
// Optional build macro: MEM_TG_RESP_CHECK_EN
//   defined   -> every non-OKAY bresp/rresp also bumps err_cnt
//   undefined -> responses are ignored and no response-check logic exists
//
// Handshake rule on every channel: a beat transfers on the rising clk edge
// where valid and ready are both high; the source holds valid and its
// payload unchanged until that edge.
module mem_axi_traffic_gen #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 512,
  parameter int ID_W      = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [15:0]           num_bursts,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [2:0]            dbg_state,
  // AW
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_W-1:0]       awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  // W
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  // B
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  // AR
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ID_W-1:0]       arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  // R
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [ID_W-1:0]       rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_AW = 3'd1,
    WR_W  = 3'd2,
    WR_B  = 3'd3,
    RD_AR = 3'd4,
    RD_R  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [7:0]        AXLEN       = 8'(BURST_LEN - 1);
  localparam logic [2:0]        AXSIZE      = 3'($clog2(DATA_W / 8));
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * (DATA_W / 8));

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_num;
  logic [15:0]         r_burst_cnt;
  logic [31:0]         r_seed;
  logic [31:0]         r_beat_idx;
  logic [7:0]          r_beat_in_burst;
  logic                r_awvalid;
  logic                r_arvalid;
  logic                r_pass;
  logic [15:0]         r_err;

  logic                w_more;
  logic                w_wlast;
  logic [31:0]         w_word;
  logic [DATA_W-1:0]   w_pattern;
  logic [1:0]          w_err_inc;
  logic [16:0]         w_err_sum;
  logic                w_unused_ok;

  // Another burst follows the one currently finishing.
  assign w_more    = (r_burst_cnt + 16'd1) < r_num;
  assign w_word    = r_seed + r_beat_idx;
  assign w_pattern = {(DATA_W/32){w_word}};
  assign w_wlast   = (r_state == WR_W) && (r_beat_in_burst == AXLEN);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (num_bursts == 16'd0) ? DONE : WR_AW;
      WR_AW:   if (r_awvalid && awready) w_next = WR_W;
      WR_W:    if (w_wlast && wready) w_next = WR_B;
      WR_B:    if (bvalid) w_next = w_more ? WR_AW : RD_AR;
      RD_AR:   if (r_arvalid && arready) w_next = RD_R;
      RD_R:    if (rvalid && rlast) w_next = w_more ? RD_AR : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Address valids rise one cycle after entering the address state and drop on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awvalid <= 1'b0;
      r_arvalid <= 1'b0;
    end else begin
      r_awvalid <= (r_state == WR_AW) && !(r_awvalid && awready);
      r_arvalid <= (r_state == RD_AR) && !(r_arvalid && arready);
    end
  end

  // Run parameters, burst address and beat counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base          <= '0;
      r_addr          <= '0;
      r_num           <= '0;
      r_seed          <= '0;
      r_burst_cnt     <= '0;
      r_beat_idx      <= '0;
      r_beat_in_burst <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_base          <= base_addr;
          r_addr          <= base_addr;
          r_num           <= num_bursts;
          r_seed          <= seed;
          r_burst_cnt     <= '0;
          r_beat_idx      <= '0;
          r_beat_in_burst <= '0;
        end
        WR_W: if (wready) begin
          r_beat_idx      <= r_beat_idx + 32'd1;
          r_beat_in_burst <= w_wlast ? 8'd0 : r_beat_in_burst + 8'd1;
        end
        WR_B: if (bvalid) begin
          if (w_more) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
            r_addr      <= r_addr + BURST_BYTES;
          end else begin
            // Read-back restarts from the first burst and the first pattern word.
            r_burst_cnt <= '0;
            r_addr      <= r_base;
            r_beat_idx  <= '0;
          end
        end
        RD_R: if (rvalid) begin
          r_beat_idx <= r_beat_idx + 32'd1;
          if (rlast && w_more) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
            r_addr      <= r_addr + BURST_BYTES;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_TG_RESP_CHECK_EN
  // Error events this cycle: read data mismatch plus non-OKAY responses.
  always_comb begin
    w_err_inc = 2'd0;
    if ((r_state == RD_R) && rvalid && (rdata != w_pattern)) w_err_inc = w_err_inc + 2'd1;
    if ((r_state == RD_R) && rvalid && (rresp != 2'b00))     w_err_inc = w_err_inc + 2'd1;
    if ((r_state == WR_B) && bvalid && (bresp != 2'b00))     w_err_inc = w_err_inc + 2'd1;
  end
  assign w_unused_ok = ^{bid, rid};
`else
  // Error events this cycle: read data mismatch only.
  always_comb begin
    w_err_inc = 2'd0;
    if ((r_state == RD_R) && rvalid && (rdata != w_pattern)) w_err_inc = 2'd1;
  end
  assign w_unused_ok = ^{bid, rid, bresp, rresp};
`endif

  assign w_err_sum = {1'b0, r_err} + {15'd0, w_err_inc};

  // Saturating error counter, cleared by an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_err <= '0;
    else if ((r_state == IDLE) && start)  r_err <= '0;
    else if (w_err_inc != 2'd0)           r_err <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  // Pass verdict latched in DONE and held until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_pass <= 1'b0;
    else if ((r_state == IDLE) && start)  r_pass <= 1'b0;
    else if (r_state == DONE)             r_pass <= (r_err == 16'd0);
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign pass      = (r_state == DONE) ? (r_err == 16'd0) : r_pass;
  assign err_cnt   = r_err;
  assign dbg_state = r_state;

  assign awvalid = r_awvalid;
  assign awid    = '0;
  assign awaddr  = r_addr;
  assign awlen   = r_awvalid ? AXLEN  : 8'd0;
  assign awsize  = r_awvalid ? AXSIZE : 3'd0;
  assign awburst = r_awvalid ? 2'b01  : 2'b00;

  assign wvalid  = (r_state == WR_W);
  assign wdata   = w_pattern;
  assign wstrb   = {(DATA_W/8){r_state == WR_W}};
  assign wlast   = w_wlast;

  assign bready  = (r_state == WR_B);

  assign arvalid = r_arvalid;
  assign arid    = '0;
  assign araddr  = r_addr;
  assign arlen   = r_arvalid ? AXLEN  : 8'd0;
  assign arsize  = r_arvalid ? AXSIZE : 3'd0;
  assign arburst = r_arvalid ? 2'b01  : 2'b00;

  assign rready  = (r_state == RD_R);

endmodule

// File: tb/tb_mem_axi_traffic_gen.sv
// Bench for mem_axi_traffic_gen: directed runs against a behavioural AXI responder.
module tb_mem_axi_traffic_gen;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 512;
  localparam int ID_W      = 8;
  localparam int BURST_LEN = 4;

  logic                clk, reset, start;
  logic [ADDR_W-1:0]   base_addr;
  logic [15:0]         num_bursts;
  logic [31:0]         seed;
  logic                busy, done, pass;
  logic [15:0]         err_cnt;
  logic [2:0]          dbg_state;
  logic                awvalid, awready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid, bready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                arvalid, arready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                rvalid, rready, rlast;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  mem_axi_traffic_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_bursts(num_bursts),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .dbg_state(dbg_state),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_ar_q[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- responder model ----------------
  logic [DATA_W-1:0] mem [logic [31:0]];
  bit          cfg_stall;
  int          cfg_corrupt;
  logic [1:0]  cfg_bresp0;
  logic [31:0] cfg_seed;
  int          aw_n, ar_n, b_n, w_k, r_k;
  logic [31:0] w_addr, rd_addr;
  int          w_beat, rd_beat;
  bit          b_pend, r_act;
  int          aw_wait, w_wait, ar_wait;
  bit          p_aw_wait, p_w_wait, p_ar_wait;
  logic [31:0] p_awaddr, p_araddr;
  logic [DATA_W-1:0] p_wdata;
  logic        p_wlast;

  // One responder step per falling edge: drive this cycle's inputs, then
  // account for the handshakes that the coming rising edge will perform.
  task automatic resp_step();
    logic [DATA_W-1:0] d;
    logic [31:0] a;
    if (reset) begin
      b_pend = 0; r_act = 0; p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
      rdata = '0; bresp = 2'b00; rresp = 2'b00; bid = '0; rid = '0;
      return;
    end
    if (p_aw_wait) check("aw_hold", {awvalid, awaddr, awlen}, {1'b1, p_awaddr, 8'd3});
    if (p_ar_wait) check("ar_hold", {arvalid, araddr, arlen}, {1'b1, p_araddr, 8'd3});
    if (p_w_wait) begin
      check("w_hold_ctl", {wvalid, wlast}, {1'b1, p_wlast});
      check("w_hold_data", wdata, p_wdata);
    end
    awready = !cfg_stall || (aw_wait == 0);
    wready  = !cfg_stall || (w_wait == 0);
    arready = !cfg_stall || (ar_wait == 0);
    bvalid  = b_pend;
    bid     = '0;
    bresp   = (b_n == 0) ? cfg_bresp0 : 2'b00;
    a       = rd_addr + 32'(rd_beat * 64);
    d       = mem.exists(a) ? mem[a] : '0;
    if (r_act && (r_k == cfg_corrupt)) d[0] = ~d[0];
    rvalid  = r_act;
    rdata   = d;
    rlast   = r_act && (rd_beat == BURST_LEN - 1);
    rresp   = 2'b00;
    rid     = '0;
    // AW
    if (awvalid && awready) begin
      if (exp_aw_q.size() > 0) check("aw_addr", awaddr, exp_aw_q.pop_front());
      else check("aw_unexpected", 1'b1, 1'b0);
      check("aw_ctl", {awid, awlen, awsize, awburst}, {8'h00, 8'd3, 3'd6, 2'b01});
      w_addr = awaddr; w_beat = 0; aw_n++;
      aw_wait = cfg_stall ? $urandom_range(0, 5) : 0;
    end else if (awvalid && aw_wait > 0) aw_wait--;
    p_aw_wait = awvalid && !awready; p_awaddr = awaddr;
    // W
    if (wvalid && wready) begin
      check("w_data", wdata, {16{cfg_seed + 32'(w_k)}});
      check("w_ctl", {wlast, wstrb}, {(w_beat == BURST_LEN - 1), 64'hFFFF_FFFF_FFFF_FFFF});
      mem[w_addr + 32'(w_beat * 64)] = wdata;
      if (wlast) b_pend = 1;
      w_beat++; w_k++;
      w_wait = cfg_stall ? $urandom_range(0, 5) : 0;
    end else if (wvalid && w_wait > 0) w_wait--;
    p_w_wait = wvalid && !wready; p_wdata = wdata; p_wlast = wlast;
    // B
    if (bvalid && bready) begin b_pend = 0; b_n++; end
    // R
    if (rvalid && rready) begin
      rd_beat++; r_k++;
      if (rlast) r_act = 0;
    end
    // AR
    if (arvalid && arready) begin
      if (exp_ar_q.size() > 0) check("ar_addr", araddr, exp_ar_q.pop_front());
      else check("ar_unexpected", 1'b1, 1'b0);
      check("ar_ctl", {arid, arlen, arsize, arburst}, {8'h00, 8'd3, 3'd6, 2'b01});
      rd_addr = araddr; rd_beat = 0; r_act = 1; ar_n++;
      ar_wait = cfg_stall ? $urandom_range(0, 5) : 0;
    end else if (arvalid && ar_wait > 0) ar_wait--;
    p_ar_wait = arvalid && !arready; p_araddr = araddr;
  endtask

  initial begin
    aw_wait = 0; w_wait = 0; ar_wait = 0; rd_addr = 0; rd_beat = 0; w_addr = 0; w_beat = 0;
    r_k = 0; w_k = 0; b_n = 0; cfg_stall = 0; cfg_corrupt = -1; cfg_bresp0 = 2'b00; cfg_seed = 0;
    forever begin
      @(negedge clk);
      resp_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_addrs(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2, input int n);
    logic [31:0] a [3];
    a[0] = a0; a[1] = a1; a[2] = a2;
    exp_aw_q.delete(); exp_ar_q.delete();
    for (int i = 0; i < n; i++) begin exp_aw_q.push_back(a[i]); exp_ar_q.push_back(a[i]); end
  endtask

  task automatic run_test(input string name, input logic [31:0] base, input logic [15:0] nb,
                          input logic [31:0] sd, input bit stall, input int corrupt,
                          input logic [1:0] bresp0, input bit restart_mid,
                          input logic [15:0] exp_err, input logic exp_pass);
    int cycles;
    @(negedge clk);
    cfg_stall = stall; cfg_corrupt = corrupt; cfg_bresp0 = bresp0; cfg_seed = sd;
    aw_n = 0; ar_n = 0; b_n = 0; w_k = 0; r_k = 0; mem.delete();
    base_addr = base; num_bursts = nb; seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = '0; num_bursts = '0; seed = '0;
    cycles = 1;
    check({name, ":busy_after_start"}, busy, 1'b1);
    if (nb != 16'd0) begin
      check({name, ":err_cleared"}, err_cnt, 16'd0);
      check({name, ":pass_cleared"}, pass, 1'b0);
    end
    if (restart_mid) begin
      repeat (3) @(negedge clk);
      base_addr = 32'h0000_5000; num_bursts = 16'd5; seed = 32'h99; start = 1'b1;
      @(negedge clk);
      start = 1'b0; base_addr = '0; num_bursts = '0; seed = '0;
      cycles += 4;
    end
    while (!done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    check({name, ":done_seen"}, done, 1'b1);
    if (nb == 16'd0) check({name, ":done_latency"}, 32'(cycles), 32'd1);
    check({name, ":err_cnt"}, err_cnt, exp_err);
    check({name, ":pass"}, pass, exp_pass);
    check({name, ":aw_count"}, 32'(aw_n), 32'(nb));
    check({name, ":ar_count"}, 32'(ar_n), 32'(nb));
    check({name, ":queues_empty"}, 32'(exp_aw_q.size() + exp_ar_q.size()), 32'd0);
    @(negedge clk);
    check({name, ":done_one_cycle"}, {done, busy}, 2'b00);
    check({name, ":pass_held"}, pass, exp_pass);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cycles;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_bursts = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("reset:status", {busy, done, pass, err_cnt, dbg_state}, 22'd0);
    check("reset:valids", {awvalid, wvalid, arvalid, bready, rready, wlast}, 6'd0);
    reset = 1'b0;

    push_addrs(32'h0, 32'h100, 32'h0, 2);
    run_test("basic", 32'h0, 16'd2, 32'h10, 0, -1, 2'b00, 0, 16'd0, 1'b1);

    push_addrs(32'h0, 32'h100, 32'h0, 2);
    run_test("corrupt", 32'h0, 16'd2, 32'h10, 0, 3, 2'b00, 0, 16'd1, 1'b0);

    push_addrs(32'h0, 32'h0, 32'h0, 0);
    run_test("zero", 32'h1234, 16'd0, 32'h10, 0, -1, 2'b00, 0, 16'd0, 1'b1);

    push_addrs(32'h0, 32'h100, 32'h0, 2);
    run_test("stall", 32'h0, 16'd2, 32'h10, 1, -1, 2'b00, 1, 16'd0, 1'b1);

    push_addrs(32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0180, 3);
    run_test("wrap", 32'hFFFF_FF80, 16'd3, 32'hFFFF_FFFE, 0, -1, 2'b00, 0, 16'd0, 1'b1);

    // Reset in the middle of the write data phase.
    push_addrs(32'h0, 32'h100, 32'h0, 2);
    @(negedge clk);
    cfg_stall = 0; cfg_corrupt = -1; cfg_bresp0 = 2'b00; cfg_seed = 32'h10;
    aw_n = 0; ar_n = 0; b_n = 0; w_k = 0; r_k = 0; mem.delete();
    base_addr = '0; num_bursts = 16'd2; seed = 32'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!wvalid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("rst_mid:wvalid_seen", wvalid, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid:outputs", {wvalid, busy, awvalid, arvalid, bready, rready, done, pass}, 8'd0);
    check("rst_mid:state", {dbg_state, err_cnt}, 19'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_addrs(32'h0, 32'h100, 32'h0, 2);
    run_test("after_rst", 32'h0, 16'd2, 32'h10, 0, -1, 2'b00, 0, 16'd0, 1'b1);

    push_addrs(32'h0, 32'h100, 32'h0, 2);
`ifdef MEM_TG_RESP_CHECK_EN
    run_test("bresp", 32'h0, 16'd2, 32'h10, 0, -1, 2'b10, 0, 16'd1, 1'b0);
`else
    run_test("bresp", 32'h0, 16'd2, 32'h10, 0, -1, 2'b10, 0, 16'd0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_axi_traffic_gen.md
MEM_AXI_TRAFFIC_GEN -- requirements
Module: mem_axi_traffic_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 32, AXI address width.
REQ-002 DATA_W, 512, AXI data width; multiple of 32.
REQ-003 ID_W, 8, AXI ID width.
REQ-004 BURST_LEN, 4, beats per burst, 1..256.
REQ-005 Ports SHALL be: clk  in  1  sole clock; all logic is synchronous to it.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle run request.
REQ-008 base_addr  in  ADDR_W  first burst address; sampled at start.
REQ-009 num_bursts  in  16  burst count; sampled at start.
REQ-010 seed  in  32  pattern seed; sampled at start.
REQ-011 busy, done, pass  out  1 each  run status.
REQ-012 err_cnt  out  16  mismatching read beats.
REQ-013 AW channel: awvalid out 1, awready in 1, awid out ID_W, awaddr out ADDR_W, awlen out 8, awsize out 3, awburst out 2.
REQ-014 W channel: wvalid out 1, wready in 1, wdata out DATA_W, wstrb out DATA_W/8, wlast out 1.
REQ-015 B channel: bvalid in 1, bready out 1, bid in ID_W, bresp in 2.
REQ-016 AR channel: arvalid out 1, arready in 1, arid out ID_W, araddr out ADDR_W, arlen out 8, arsize out 3, arburst out 2.
REQ-017 R channel: rvalid in 1, rready out 1, rid in ID_W, rdata in DATA_W, rresp in 2, rlast in 1.

Function
REQ-018 The block SHALL act as AXI-MM initiator toward the EMIF AXI-MM responder: write num_bursts bursts, then read back and compare them.
REQ-019 FSM states SHALL be IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE.
REQ-020 IDLE->WR_AW on start when num_bursts!=0; IDLE->DONE on start when num_bursts==0.
REQ-021 WR_AW->WR_W on awvalid&awready; WR_W->WR_B on wlast beat accepted; WR_B->WR_AW on bvalid if bursts remain, else ->RD_AR with burst counter cleared.
REQ-022 RD_AR->RD_R on arvalid&arready; RD_R->RD_AR on rlast beat if bursts remain, else ->DONE.
REQ-023 DONE SHALL assert done and pass=(err_cnt==0) for exactly one cycle, then ->IDLE; pass SHALL hold until next start.
REQ-024 Only one transaction SHALL be outstanding; awvalid/arvalid asserted the cycle after entering WR_AW/RD_AR.
REQ-025 valid SHALL stay high and payload stable until ready; bready=1 only in WR_B; rready=1 only in RD_R.
REQ-026 Burst n address SHALL be base_addr + n*BURST_LEN*(DATA_W/8), modulo 2^ADDR_W (wrap permitted).
REQ-027 awlen=arlen=BURST_LEN-1; awsize=arsize=log2(DATA_W/8); awburst=arburst=2'b01; awid=arid=0; wstrb all ones.
REQ-028 Beat k (global index from 0) data SHALL be DATA_W/32 copies of (seed+k) mod 2^32.
REQ-029 Each read beat unequal to its expected pattern SHALL increment err_cnt, saturating at 16'hFFFF.
REQ-030 start while busy SHALL be ignored; busy=1 in every state except IDLE.
REQ-031 err_cnt SHALL clear on accepted start.

Reset
REQ-032 reset SHALL force IDLE and all outputs to 0 immediately, including mid-burst valids.
REQ-033 Sampled control registers and counters SHALL reset to 0.

Configuration
REQ-034 MEM_TG_RESP_CHECK_EN defined: each bresp or rresp != 2'b00 SHALL also increment err_cnt (saturating).
REQ-035 MEM_TG_RESP_CHECK_EN undefined: bresp/rresp SHALL be ignored; the response-check logic SHALL be absent.

Verification
REQ-036 Ideal responder, base 0x0, num_bursts=2, seed=0x10, BURST_LEN=4 -> AW addrs 0x0, 0x100; wdata words 0x10..0x17; done pulse, pass=1, err_cnt=0.
REQ-037 Responder corrupts read beat 3 -> err_cnt=1, pass=0.
REQ-038 num_bursts=0 -> done one cycle after start; no AW/AR issued; pass=1.
REQ-039 awready/wready/arready randomly low for 0-5 cycles -> payloads stable while valid is high; result identical to REQ-036.
REQ-040 reset asserted during WR_W -> wvalid=0 and busy=0 in the same cycle; new start runs cleanly.
REQ-041 With MEM_TG_RESP_CHECK_EN, bresp=2'b10 on burst 0 and clean reads -> err_cnt=1, pass=0; without the macro -> pass=1.
